// File: rtl/immediate_generator_pkg.sv
// Shared decode constants for the immediate generator: format select
// encodings and the JAL opcode that splits U-type from J-type.
package immediate_generator_pkg;

  typedef enum logic [1:0] {
    IMM_I  = 2'b00,
    IMM_S  = 2'b01,
    IMM_B  = 2'b10,
    IMM_UJ = 2'b11
  } imm_sel_t;

  localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage : immediate_generator_pkg

// File: rtl/immediate_generator.sv
// RV32I immediate extraction for the decode stage; purely combinational
// unless REGISTER_OUTPUT=1, which adds one cycle of latency.
module immediate_generator
  import immediate_generator_pkg::*;
#(
  parameter bit REGISTER_OUTPUT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [1:0]  imm_sel,
  output logic [31:0] immediate
);

  logic [31:0] immediate_d;
  imm_sel_t    sel;
  logic [6:0]  opcode;
  logic        sign;

  assign sel    = imm_sel_t'(imm_sel);
  assign opcode = instruction[6:0];
  assign sign   = instruction[31];

  always_comb begin
    // NOTE: a default before the case keeps this block latch-free even if an arm is edited later.
    immediate_d = 32'h0000_0000;
    unique case (sel)
      IMM_I: immediate_d = {{20{sign}}, instruction[31:20]};
      IMM_S: immediate_d = {{20{sign}}, instruction[31:25], instruction[11:7]};
      IMM_B: immediate_d = {{19{sign}}, sign, instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
      IMM_UJ: begin
        // Only the opcode decides J versus U; every other UJ encoding is U-type.
        if (opcode == OP_JAL) begin
          immediate_d = {{11{sign}}, sign, instruction[19:12], instruction[20],
                         instruction[30:21], 1'b0};
        end else begin
          immediate_d = {instruction[31:12], 12'h000};
        end
      end
      default: immediate_d = 32'h0000_0000;
    endcase
  end

  generate
    if (REGISTER_OUTPUT) begin : g_reg
      logic [31:0] immediate_q;

      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (rst) begin
          immediate_q <= 32'h0000_0000;
        end else begin
          immediate_q <= immediate_d;
        end
      end

      assign immediate = immediate_q;
    end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign immediate      = immediate_d;
    end
  endgenerate

endmodule : immediate_generator

// File: tb/tb_immediate_generator.sv
// Directed-vector bench: a combinational instance and a registered instance
// driven from the same inputs, checked against hand-computed immediates.
module tb_immediate_generator;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [1:0]  imm_sel;
  logic [31:0] imm_comb;
  logic [31:0] imm_reg;

  int checks;
  int errors;

  immediate_generator #(.REGISTER_OUTPUT(1'b0)) u_comb (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .imm_sel     (imm_sel),
    .immediate   (imm_comb)
  );

  immediate_generator #(.REGISTER_OUTPUT(1'b1)) u_reg (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .imm_sel     (imm_sel),
    .immediate   (imm_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [1:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    instruction = 32'h0000_0000;
    imm_sel     = 2'b00;

    vecs.push_back('{"i_neg1",     32'hFFF00093, 2'b00, 32'hFFFFFFFF});
    vecs.push_back('{"i_max",      32'h7FF00093, 2'b00, 32'h000007FF});
    vecs.push_back('{"i_min",      32'h80000013, 2'b00, 32'hFFFFF800});
    vecs.push_back('{"s_zero",     32'h00112023, 2'b01, 32'h00000000});
    vecs.push_back('{"s_neg4",     32'hFE112E23, 2'b01, 32'hFFFFFFFC});
    vecs.push_back('{"s_min",      32'h80000023, 2'b01, 32'hFFFFF800});
    vecs.push_back('{"b_zero",     32'h00208063, 2'b10, 32'h00000000});
    vecs.push_back('{"b_neg4",     32'hFE208EE3, 2'b10, 32'hFFFFFFFC});
    vecs.push_back('{"b_min",      32'h80000063, 2'b10, 32'hFFFFF000});
    vecs.push_back('{"b_bit7",     32'h00000F80, 2'b10, 32'h0000081E});
    vecs.push_back('{"j_zero",     32'h0000006F, 2'b11, 32'h00000000});
    vecs.push_back('{"j_neg4",     32'hFFDFF06F, 2'b11, 32'hFFFFFFFC});
    vecs.push_back('{"j_min",      32'h8000006F, 2'b11, 32'hFFF00000});
    vecs.push_back('{"j_bit20",    32'h0010006F, 2'b11, 32'h00000800});
    vecs.push_back('{"u_lui",      32'h12345037, 2'b11, 32'h12345000});
    vecs.push_back('{"u_auipc",    32'hFFFFF017, 2'b11, 32'hFFFFF000});
    vecs.push_back('{"u_notjal",   32'h8010006E, 2'b11, 32'h80100000});

    // Combinational instance: result visible without any clock edge.
    foreach (vecs[k]) begin
      @(negedge clk);
      instruction = vecs[k].instr;
      imm_sel     = vecs[k].sel;
      #1;
      check(vecs[k].tag, imm_comb, vecs[k].exp);
    end

    // Registered instance: reset held for two edges.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reg_reset", imm_reg, 32'h0000_0000);

    @(negedge clk);
    rst         = 1'b0;
    instruction = 32'hFFF00093;
    imm_sel     = 2'b00;
    #1;
    check("reg_pre_edge", imm_reg, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reg_first", imm_reg, 32'hFFFFFFFF);

    @(negedge clk);
    instruction = 32'h12345037;
    imm_sel     = 2'b11;
    #1;
    check("reg_hold", imm_reg, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check("reg_lui", imm_reg, 32'h12345000);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reg_rst_again", imm_reg, 32'h0000_0000);

    @(negedge clk);
    rst         = 1'b0;
    instruction = 32'hFE208EE3;
    imm_sel     = 2'b10;
    @(posedge clk);
    #1;
    check("reg_b_after_rst", imm_reg, 32'hFFFFFFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_immediate_generator
